// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned WORD_OFF    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: one word access per load/store over req/ack, stalling the pipeline.
// Optional DMEM_ALIGN_CHECK_EN: misaligned requests skip memory and set the sticky misalign_o flag.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] WriteData_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_we;
    logic              w_access;
    logic              w_misaligned;
    logic              w_issue;

    assign w_access = MemRead_i | MemWrite_i;

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_misaligned = (Addr_i[WORD_OFF-1:0] != '0);
    assign misalign_o   = r_misalign;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_misalign <= 1'b0;
        end else if (r_state == IDLE && w_access && w_misaligned) begin
            r_misalign <= 1'b1;
        end
    end
`else
    logic w_unused_offset;

    assign w_misaligned    = 1'b0;
    assign w_unused_offset = ^Addr_i[WORD_OFF-1:0];
`endif

    assign w_issue = (r_state == IDLE) & w_access & ~w_misaligned;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_access) w_next = w_misaligned ? DONE : REQ;
            REQ:     if (mem_ack_i) w_next = DONE;
            // Inputs during DONE are the request just serviced; never re-issue it.
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_issue) begin
            r_addr  <= {Addr_i[ADDR_W-1:WORD_OFF], {WORD_OFF{1'b0}}};
            r_wdata <= WriteData_i;
            r_we    <= ~MemRead_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (r_state == REQ && mem_ack_i && !r_we) begin
            r_rdata <= mem_rdata_i;
        end
    end

    assign stall_o     = ((r_state == IDLE) & w_access) | (r_state == REQ);
    assign mem_req_o   = (r_state == REQ);
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign ReadData_o  = r_rdata;

endmodule
